// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared types and constants for the program-counter sequencer.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_e;

  localparam logic [31:0] PC_INCR      = 32'd4;
  localparam int          JUMP_INDEX_W = 26;
  localparam int          JUMP_HI_W    = 4;

  // Jump target keeps the 256 MB region of the sequential PC and word-aligns the index.
  function automatic logic [31:0] jump_target(input logic [JUMP_HI_W-1:0]    pc_plus4_hi,
                                              input logic [JUMP_INDEX_W-1:0] index);
    return {pc_plus4_hi, index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory handshake plus the core's per-instruction controls.
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic                    imem_req;
  logic [31:0]             imem_addr;
  logic                    imem_ack;
  logic                    instr_valid;
  logic                    exec_done;
  logic                    branch;
  logic                    zero;
  logic                    jump;
  logic                    halt;
  logic [31:0]             branch_offset;
  logic [JUMP_INDEX_W-1:0] jump_index;

  // Sequencer side
  modport master (
    output imem_req, imem_addr, instr_valid,
    input  imem_ack, exec_done, branch, zero, jump, halt, branch_offset, jump_index
  );

  // Memory / core side
  modport slave (
    input  imem_req, imem_addr, instr_valid,
    output imem_ack, exec_done, branch, zero, jump, halt, branch_offset, jump_index
  );

endinterface

// File: rtl/pc_sequencer_pc_next_sel.sv
// pc_sequencer_pc_next_sel: combinational next-PC mux (halt > jump > taken branch > PC+4)
// and the branch-taken select.
module pc_sequencer_pc_next_sel
  import pc_sequencer_pkg::*;
(
  input  logic [31:0]             pc,
  input  logic                    in_exec,
  input  logic                    branch,
  input  logic                    zero,
  input  logic                    jump,
  input  logic                    halt,
  input  logic [31:0]             branch_offset,
  input  logic [JUMP_INDEX_W-1:0] jump_index,
  output logic [31:0]             pc_next,
  output logic                    pc_src
);

  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic        br_taken;

  // Candidate targets; all arithmetic wraps modulo 2^32, offset bits shifted out are lost.
  always_comb begin
    pc_plus4   = pc + PC_INCR;
    branch_tgt = pc_plus4 + (branch_offset << 2);
    jump_tgt   = jump_target(pc_plus4[31:32-JUMP_HI_W], jump_index);
    br_taken   = branch & zero;
  end

  // Priority select; pc_src is reported only while an instruction is executing.
  always_comb begin
    pc_next = pc_plus4;
    if (halt)          pc_next = pc;
    else if (jump)     pc_next = jump_tgt;
    else if (br_taken) pc_next = branch_tgt;
    pc_src = br_taken & in_exec;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter owner; fetches via req/ack, waits for exec_done,
// then advances to the selected next PC.
// Optional feature macro: PC_SEQ_BRANCH_STATS_EN adds saturating taken/not-taken branch counters.
//
// state  | meaning
// IDLE   | waiting for start, no fetch outstanding
// FETCH  | imem_req high at imem_addr=pc until imem_ack
// EXEC   | instruction executing, instr_valid high until exec_done
// HALTED | halt executed; only reset leaves
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef PC_SEQ_BRANCH_STATS_EN
  , parameter int STATS_W = 16
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  pc_sequencer_if.master      bus,
  output logic [31:0]         pc,
  output logic                pc_src,
  output logic                halted
`ifdef PC_SEQ_BRANCH_STATS_EN
  , output logic [STATS_W-1:0] branch_taken_cnt
  , output logic [STATS_W-1:0] branch_not_taken_cnt
`endif
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_next;
  logic        in_exec;
  logic        retire;

  assign in_exec = (state_q == ST_EXEC);
  assign retire  = in_exec & bus.exec_done;

  pc_sequencer_pc_next_sel u_pc_next_sel (
    .pc            (pc_q),
    .in_exec       (in_exec),
    .branch        (bus.branch),
    .zero          (bus.zero),
    .jump          (bus.jump),
    .halt          (bus.halt),
    .branch_offset (bus.branch_offset),
    .jump_index    (bus.jump_index),
    .pc_next       (pc_next),
    .pc_src        (pc_src)
  );

  // State and PC registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state and next-PC; inputs outside their owning state are ignored
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  if (bus.imem_ack) state_d = ST_EXEC;
      ST_EXEC: begin
        if (bus.exec_done) begin
          pc_d    = pc_next;
          state_d = bus.halt ? ST_HALTED : ST_FETCH;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from state
  always_comb begin
    bus.imem_req    = (state_q == ST_FETCH);
    bus.imem_addr   = pc_q;
    bus.instr_valid = (state_q == ST_EXEC);
    halted          = (state_q == ST_HALTED);
    pc              = pc_q;
  end

`ifdef PC_SEQ_BRANCH_STATS_EN
  logic [STATS_W-1:0] taken_q, taken_d;
  logic [STATS_W-1:0] not_taken_q, not_taken_d;
  logic               count_br;

  assign count_br = retire & bus.branch & ~bus.jump & ~bus.halt;

  // Saturating branch counters, only for retired plain conditional branches
  always_comb begin
    taken_d     = taken_q;
    not_taken_d = not_taken_q;
    if (count_br) begin
      if (bus.zero) begin
        if (taken_q != {STATS_W{1'b1}}) taken_d = taken_q + 1'b1;
      end else begin
        if (not_taken_q != {STATS_W{1'b1}}) not_taken_d = not_taken_q + 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_q     <= '0;
      not_taken_q <= '0;
    end else begin
      taken_q     <= taken_d;
      not_taken_q <= not_taken_d;
    end
  end

  assign branch_taken_cnt     = taken_q;
  assign branch_not_taken_cnt = not_taken_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of fetch sequencing, next-PC selection, halt and reset.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] pc;
  logic        pc_src;
  logic        halted;
  int          n_assert;
  int          n_fail;

  pc_sequencer_if bus ();

`ifdef PC_SEQ_BRANCH_STATS_EN
  logic [1:0] branch_taken_cnt;
  logic [1:0] branch_not_taken_cnt;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .STATS_W(2)) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .bus                  (bus.master),
    .pc                   (pc),
    .pc_src               (pc_src),
    .halted               (halted),
    .branch_taken_cnt     (branch_taken_cnt),
    .branch_not_taken_cnt (branch_not_taken_cnt)
  );
`else
  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bus    (bus.master),
    .pc     (pc),
    .pc_src (pc_src),
    .halted (halted)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctl();
    bus.exec_done     = 1'b0;
    bus.branch        = 1'b0;
    bus.zero          = 1'b0;
    bus.jump          = 1'b0;
    bus.halt          = 1'b0;
    bus.branch_offset = 32'h0;
    bus.jump_index    = 26'h0;
  endtask

  // One instruction: fetch acked on the first req cycle, exec_done on the first EXEC cycle.
  task automatic fetch_exec(input string tag, input logic [31:0] exp_addr,
                            input logic br, input logic z, input logic jmp,
                            input logic [31:0] off, input logic [25:0] idx,
                            input logic exp_src);
    chk({tag, "_req"}, {31'h0, bus.imem_req}, 32'd1);
    chk({tag, "_addr"}, bus.imem_addr, exp_addr);
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    chk({tag, "_valid"}, {31'h0, bus.instr_valid}, 32'd1);
    bus.branch        = br;
    bus.zero          = z;
    bus.jump          = jmp;
    bus.branch_offset = off;
    bus.jump_index    = idx;
    bus.exec_done     = 1'b1;
    #1;
    chk({tag, "_pc_src"}, {31'h0, pc_src}, {31'h0, exp_src});
    step();
    clear_ctl();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    bus.imem_ack = 1'b0;
    clear_ctl();
    step();
    step();

    chk("rst_pc",     pc, 32'h0);
    chk("rst_req",    {31'h0, bus.imem_req}, 32'd0);
    chk("rst_valid",  {31'h0, bus.instr_valid}, 32'd0);
    chk("rst_pc_src", {31'h0, pc_src}, 32'd0);
    chk("rst_halted", {31'h0, halted}, 32'd0);

    reset = 1'b0;
    chk("idle_req", {31'h0, bus.imem_req}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;

    fetch_exec("seq0", 32'h0000_0000, 0, 0, 0, 32'h0, 26'h0, 0);
    fetch_exec("seq1", 32'h0000_0004, 0, 0, 0, 32'h0, 26'h0, 0);
    fetch_exec("jmp100", 32'h0000_0008, 0, 0, 1, 32'h0, 26'h40, 0);
    fetch_exec("br_taken", 32'h0000_0100, 1, 1, 0, 32'hFFFF_FFFC, 26'h0, 1);
    fetch_exec("jmp_back", 32'h0000_00F4, 0, 0, 1, 32'h0, 26'h40, 0);
    fetch_exec("br_not", 32'h0000_0100, 1, 0, 0, 32'hFFFF_FFFC, 26'h0, 0);
    fetch_exec("br_far", 32'h0000_0104, 1, 1, 0, 32'h03FF_FFBE, 26'h0, 1);
    fetch_exec("jmp_wins", 32'h1000_0000, 1, 1, 1, 32'h0, 26'h3, 1);
    fetch_exec("off_trunc", 32'h1000_000C, 1, 1, 0, 32'h4000_0001, 26'h0, 1);

    // Core controls while still fetching must be ignored
    bus.branch    = 1'b1;
    bus.zero      = 1'b1;
    bus.halt      = 1'b1;
    bus.exec_done = 1'b1;
    #1;
    chk("fetch_pc_src", {31'h0, pc_src}, 32'd0);
    chk("fetch_valid", {31'h0, bus.instr_valid}, 32'd0);
    step();
    chk("fetch_hold_req", {31'h0, bus.imem_req}, 32'd1);
    chk("fetch_hold_addr", bus.imem_addr, 32'h1000_0014);
    clear_ctl();

    // EXEC held open until exec_done, then halt beats jump
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    step();
    chk("exec_wait_valid", {31'h0, bus.instr_valid}, 32'd1);
    chk("exec_wait_req", {31'h0, bus.imem_req}, 32'd0);
    bus.halt       = 1'b1;
    bus.jump       = 1'b1;
    bus.jump_index = 26'h3FF;
    bus.exec_done  = 1'b1;
    step();
    clear_ctl();
    chk("halt_halted", {31'h0, halted}, 32'd1);
    chk("halt_req", {31'h0, bus.imem_req}, 32'd0);
    chk("halt_valid", {31'h0, bus.instr_valid}, 32'd0);
    chk("halt_pc", pc, 32'h1000_0014);
    start        = 1'b1;
    bus.imem_ack = 1'b1;
    step();
    step();
    start        = 1'b0;
    bus.imem_ack = 1'b0;
    chk("halt_start_halted", {31'h0, halted}, 32'd1);
    chk("halt_start_req", {31'h0, bus.imem_req}, 32'd0);
    chk("halt_start_pc", pc, 32'h1000_0014);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("unhalt_halted", {31'h0, halted}, 32'd0);
    chk("unhalt_pc", pc, 32'h0);
    chk("unhalt_req", {31'h0, bus.imem_req}, 32'd0);

    // Reset while a delayed fetch is outstanding
    start = 1'b1;
    step();
    start = 1'b0;
    fetch_exec("post_rst", 32'h0000_0000, 0, 0, 0, 32'h0, 26'h0, 0);
    step();
    chk("wait1_req", {31'h0, bus.imem_req}, 32'd1);
    chk("wait1_addr", bus.imem_addr, 32'h0000_0004);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_fetch_req", {31'h0, bus.imem_req}, 32'd0);
    chk("rst_fetch_pc", pc, 32'h0);
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    chk("late_ack_req", {31'h0, bus.imem_req}, 32'd0);
    chk("late_ack_valid", {31'h0, bus.instr_valid}, 32'd0);
    chk("late_ack_pc", pc, 32'h0);

    // Sequencing resumes normally from IDLE
    start = 1'b1;
    step();
    start = 1'b0;
    fetch_exec("restart", 32'h0000_0000, 0, 0, 0, 32'h0, 26'h0, 0);
    chk("restart_next", bus.imem_addr, 32'h0000_0004);

`ifdef PC_SEQ_BRANCH_STATS_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("stat_rst_taken", {30'h0, branch_taken_cnt}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fetch_exec("stat_br", 32'(i * 4), 1, 1, 0, 32'h0, 26'h0, 1);
    end
    chk("stat_taken_sat", {30'h0, branch_taken_cnt}, 32'd3);
    chk("stat_not_taken", {30'h0, branch_not_taken_cnt}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Owns the program counter and sequences instruction fetch and next-PC selection for the processor core. Issues one fetch to instruction memory with a req/ack handshake, holds the instruction window open until the core reports execute complete, then selects PC+4, branch target (branch taken when Branch & Zero) or jump target. Sits between the instruction memory port and the core's control unit/ALU, replacing the free-running PC register and the standalone branch-select gate.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- STATS_W, 16, width of branch statistics counters (used only with PC_SEQ_BRANCH_STATS_EN)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin sequencing from IDLE
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (equals pc)
- imem_ack  in  1  fetch complete; instruction data valid this cycle
- instr_valid  out  1  high while instruction is executing (EXEC state)
- exec_done  in  1  core finished current instruction; next-PC controls valid this cycle
- branch  in  1  conditional branch instruction
- zero  in  1  ALU zero flag
- jump  in  1  jump instruction
- halt  in  1  halt instruction
- branch_offset  in  32  sign-extended word offset
- jump_index  in  26  jump instruction index field
- pc  out  32  current PC
- pc_src  out  1  branch taken: branch & zero & instr_valid
- halted  out  1  high in HALTED
- branch_taken_cnt  out  STATS_W  taken branches (macro only)
- branch_not_taken_cnt  out  STATS_W  not-taken branches (macro only)

## Operation
- States: IDLE, FETCH, EXEC, HALTED.
- IDLE: imem_req=0; start=1 -> FETCH.
- FETCH: imem_req=1, imem_addr=pc; imem_ack=1 -> EXEC.
- EXEC: instr_valid=1; on exec_done:
  - Priority: halt > jump > branch taken > sequential.
  - halt: pc unchanged -> HALTED.
  - jump: pc <= {pc_plus4[31:28], jump_index, 2'b00} -> FETCH.
  - branch & zero: pc <= pc_plus4 + (branch_offset << 2) -> FETCH.
  - otherwise: pc <= pc + 4 -> FETCH.
- HALTED: leaves only on reset; start ignored.
- Arithmetic modulo 2^32; wrap past 32'hFFFF_FFFC without flag. Bits shifted out of branch_offset discarded.
- imem_ack outside FETCH ignored; exec_done, branch, zero, jump, halt outside EXEC ignored.

## Timing
- Reset values: pc=RESET_PC, imem_req=0, instr_valid=0, pc_src=0, halted=0, counters=0, state=IDLE.
- start sampled in IDLE -> imem_req high next cycle.
- imem_req and imem_addr stable until imem_ack sampled; imem_ack same cycle as req is accepted.
- EXEC entered cycle after ack; exec_done may be high on first EXEC cycle.
- Minimum 2 cycles per instruction (1 FETCH + 1 EXEC); new pc visible on imem_addr the cycle after exec_done.
- pc_src combinational from inputs, gated by EXEC.
- reset during FETCH/EXEC wins at next edge: imem_req drops, pending ack discarded, pc=RESET_PC.

## Configuration
- PC_SEQ_BRANCH_STATS_EN defined: branch_taken_cnt / branch_not_taken_cnt ports exist; counted on exec_done with branch=1, jump=0, halt=0; saturate at all-ones; cleared on reset.
- Undefined: counter ports and logic absent; sequencing identical.

## Structure
- Shared package: state enum (IDLE, FETCH, EXEC, HALTED), PC_INCR=4, jump-target field widths.
- One sub-module: pc_next_sel (combinational next-PC mux and adders, also drives pc_src); FSM and PC register in top.

## Test plan
- Reset then start, imem_ack on first req cycle, exec_done first EXEC cycle, no controls -> imem_addr 0x0, 0x4, 0x8 on successive fetches, 2 cycles apart.
- pc=0x100, branch=1, zero=1, offset=-4 -> pc_src=1, next fetch 0xF4; same with zero=0 -> 0x104, pc_src=0.
- pc=0x1000_0000, jump=1, branch=1, zero=1, jump_index=0x3 -> next fetch 0x1000_000C (jump wins).
- halt=1 with exec_done -> halted=1, imem_req stays 0, pc held, start ignored; reset -> pc=RESET_PC, IDLE.
- imem_ack delayed 3 cycles with reset asserted in second wait cycle -> imem_req 0 after the edge, pc=RESET_PC, late ack ignored.
- With PC_SEQ_BRANCH_STATS_EN, STATS_W=2: 5 taken branches -> branch_taken_cnt=3 (saturated), not-taken unchanged.
